// File: rtl/cv32e40p_pkg.sv
// Shared register-file constants and helpers for the cv32e40p register file
// with reservation scoreboard.
package cv32e40p_pkg;

    localparam int REGFILE_NUM_RD_MAX = 4;
    localparam int REGFILE_ADDR_WIDTH = 6;
    // Address bit that selects the FP bank at the default address width.
    localparam int REGFILE_FP_SEL_BIT = REGFILE_ADDR_WIDTH - 1;

    function automatic int regfile_num_tot(input int addr_width, input int fpu, input int zfinx);
        if ((fpu == 0) || (zfinx == 1)) begin
            return 1 << (addr_width - 1);
        end else begin
            return 1 << addr_width;
        end
    endfunction

endpackage

// File: rtl/cv32e40p_rf_scoreboard.sv
// Reservation scoreboard: one busy bit per register, reservation handshake
// and a registered count of outstanding reservations.
module cv32e40p_rf_scoreboard
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RD     = 3,
    parameter bit FP_BANK    = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD-1:0]                rbusy_o,
    input  logic [ADDR_WIDTH-1:0]            waddr_b_i,
    input  logic                             we_b_i,
    input  logic                             rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    output logic                             rsv_ready_o,
    input  logic                             flush_i,
    output logic [ADDR_WIDTH:0]              busy_cnt_o
);

    localparam int IDX_W   = FP_BANK ? ADDR_WIDTH : ADDR_WIDTH - 1;
    localparam int NUM_TOT = 1 << IDX_W;

    logic [NUM_TOT-1:0]   busy_q, busy_d;
    logic [ADDR_WIDTH:0]  busy_cnt_q, busy_cnt_d;
    logic                 set_s, clr_s, inc_s, dec_s;
    logic                 rsv_busy_s, rsv_clr_s;
    logic [IDX_W-1:0]     rsv_idx_s, b_idx_s;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != {ADDR_WIDTH{1'b0}}) && (FP_BANK || !a[ADDR_WIDTH-1]);
    endfunction

    assign rsv_idx_s   = rsv_addr_i[IDX_W-1:0];
    assign b_idx_s     = waddr_b_i[IDX_W-1:0];
    assign rsv_busy_s  = addr_ok(rsv_addr_i) && busy_q[rsv_idx_s];
    assign rsv_clr_s   = we_b_i && (waddr_b_i == rsv_addr_i);
    assign rsv_ready_o = rsv_valid_i && (!rsv_busy_s || rsv_clr_s) && !flush_i;

    // Effective set/clear and counter deltas; a set and clear on one register cancel.
    always_comb begin
        set_s = rsv_ready_o && addr_ok(rsv_addr_i);
        clr_s = we_b_i && addr_ok(waddr_b_i) && busy_q[b_idx_s];
        inc_s = set_s && !busy_q[rsv_idx_s];
        dec_s = clr_s && !(set_s && (b_idx_s == rsv_idx_s));
    end

    // Next busy vector and count; flush overrides everything.
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (flush_i) begin
            busy_d     = {NUM_TOT{1'b0}};
            busy_cnt_d = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (clr_s) begin
                busy_d[b_idx_s] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            if (set_s) begin
                busy_d[rsv_idx_s] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
            case ({inc_s, dec_s})
                2'b10:   busy_cnt_d = busy_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                2'b01:   busy_cnt_d = busy_cnt_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
                default: busy_cnt_d = busy_cnt_q;
            endcase
        end
    end

    // Busy bits and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= {NUM_TOT{1'b0}};
            busy_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read-port busy lookup from registered state only.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_ok(raddr_i[i])) begin
                rbusy_o[i] = busy_q[raddr_i[i][IDX_W-1:0]];
            end else begin
                rbusy_o[i] = 1'b0;
            end
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/cv32e40p_register_file_sb.sv
// Flip-flop register file with two write ports, optional same-cycle
// forwarding and a reservation scoreboard for long-latency writes.
module cv32e40p_register_file_sb
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RD-1:0]                rbusy_o,
    input  logic [ADDR_WIDTH-1:0]            waddr_a_i,
    input  logic [DATA_WIDTH-1:0]            wdata_a_i,
    input  logic                             we_a_i,
    input  logic [ADDR_WIDTH-1:0]            waddr_b_i,
    input  logic [DATA_WIDTH-1:0]            wdata_b_i,
    input  logic                             we_b_i,
    input  logic                             rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    output logic                             rsv_ready_o,
    input  logic                             flush_i,
    output logic [ADDR_WIDTH:0]              busy_cnt_o
);

    localparam int NUM_TOT = regfile_num_tot(ADDR_WIDTH, FPU, ZFINX);
    localparam bit FP_BANK = (NUM_TOT == (1 << ADDR_WIDTH));
    localparam int IDX_W   = FP_BANK ? ADDR_WIDTH : ADDR_WIDTH - 1;

    logic [NUM_TOT-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

    // Address 0 is hardwired zero; the FP half is absent without an FP bank.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != {ADDR_WIDTH{1'b0}}) && (FP_BANK || !a[ADDR_WIDTH-1]);
    endfunction

    // Next register contents; port B is applied last so it wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (we_a_i && addr_ok(waddr_a_i)) begin
            mem_d[waddr_a_i[IDX_W-1:0]] = wdata_a_i;
        end else begin
            mem_d = mem_d;
        end
        if (we_b_i && addr_ok(waddr_b_i)) begin
            mem_d[waddr_b_i[IDX_W-1:0]] = wdata_b_i;
        end else begin
            mem_d = mem_d;
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read with optional forwarding of this cycle's write data.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (!addr_ok(raddr_i[i])) begin
                rdata_o[i] = {DATA_WIDTH{1'b0}};
            end else if ((BYPASS == 1) && we_b_i && (waddr_b_i == raddr_i[i])) begin
                rdata_o[i] = wdata_b_i;
            end else if ((BYPASS == 1) && we_a_i && (waddr_a_i == raddr_i[i])) begin
                rdata_o[i] = wdata_a_i;
            end else begin
                rdata_o[i] = mem_q[raddr_i[i][IDX_W-1:0]];
            end
        end
    end

    cv32e40p_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .FP_BANK    (FP_BANK)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr_i     (raddr_i),
        .rbusy_o     (rbusy_o),
        .waddr_b_i   (waddr_b_i),
        .we_b_i      (we_b_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .rsv_ready_o (rsv_ready_o),
        .flush_i     (flush_i),
        .busy_cnt_o  (busy_cnt_o)
    );

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// Directed self-checking bench for cv32e40p_register_file_sb with the FP bank
// enabled (FPU=1, ZFINX=0, BYPASS=1).
module tb_cv32e40p_register_file_sb;

    logic              clk;
    logic              rst_n;
    logic [2:0][5:0]   raddr;
    logic [2:0][31:0]  rdata;
    logic [2:0]        rbusy;
    logic [5:0]        waddr_a, waddr_b, rsv_addr;
    logic [31:0]       wdata_a, wdata_b;
    logic              we_a, we_b, rsv_valid, rsv_ready, flush;
    logic [6:0]        busy_cnt;

    int tests_run;
    int tests_failed;

    cv32e40p_register_file_sb #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .FPU        (1),
        .ZFINX      (0),
        .NUM_RD     (3),
        .BYPASS     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .rbusy_o     (rbusy),
        .waddr_a_i   (waddr_a),
        .wdata_a_i   (wdata_a),
        .we_a_i      (we_a),
        .waddr_b_i   (waddr_b),
        .wdata_b_i   (wdata_b),
        .we_b_i      (we_b),
        .rsv_valid_i (rsv_valid),
        .rsv_addr_i  (rsv_addr),
        .rsv_ready_o (rsv_ready),
        .flush_i     (flush),
        .busy_cnt_o  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
        waddr_a = 6'd0; waddr_b = 6'd0; rsv_addr = 6'd0;
        wdata_a = 32'h0; wdata_b = 32'h0;
    endtask

    task automatic reserve(input logic [5:0] a);
        rsv_valid = 1'b1; rsv_addr = a;
        #1;
        check("rsv_ready_seq", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle();
        raddr = {6'd5, 6'd3, 6'd0};
        rst_n = 1'b0;
        #12;
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_rbusy", 64'(rbusy), 64'd0);
        check("reset_cnt", 64'(busy_cnt), 64'd0);
        check("reset_ready", 64'(rsv_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Port A write to x5 with same-cycle forwarding, then registered read.
        we_a = 1'b1; waddr_a = 6'd5; wdata_a = 32'hDEADBEEF;
        raddr = {6'd0, 6'd0, 6'd5};
        #1;
        check("bypass_a_x5", 64'(rdata[0]), 64'hDEADBEEF);
        tick();
        idle();
        #1;
        check("read_x5", 64'(rdata[0]), 64'hDEADBEEF);
        check("read_x0", 64'(rdata[1]), 64'd0);

        // A and B collide on x7; B wins both in forwarding and in storage.
        we_a = 1'b1; waddr_a = 6'd7; wdata_a = 32'h1;
        we_b = 1'b1; waddr_b = 6'd7; wdata_b = 32'h2;
        raddr = {6'd5, 6'd0, 6'd7};
        #1;
        check("bypass_ab_x7", 64'(rdata[0]), 64'h2);
        tick();
        idle();
        #1;
        check("read_x7", 64'(rdata[0]), 64'h2);
        check("read_x5_p2", 64'(rdata[2]), 64'hDEADBEEF);

        // Reservation handshake on x3.
        raddr = {6'd0, 6'd0, 6'd3};
        rsv_valid = 1'b1; rsv_addr = 6'd3;
        #1;
        check("rsv_x3_ready", 64'(rsv_ready), 64'd1);
        check("rsv_x3_busy_pre", 64'(rbusy[0]), 64'd0);
        tick();
        check("rsv_x3_cnt", 64'(busy_cnt), 64'd1);
        check("rsv_x3_busy", 64'(rbusy[0]), 64'd1);
        check("rsv_x3_again", 64'(rsv_ready), 64'd0);
        tick();
        check("refused_cnt", 64'(busy_cnt), 64'd1);
        we_b = 1'b1; waddr_b = 6'd3; wdata_b = 32'h33;
        #1;
        check("rsv_clr_ready", 64'(rsv_ready), 64'd1);
        tick();
        idle();
        #1;
        check("rsv_clr_busy", 64'(rbusy[0]), 64'd1);
        check("rsv_clr_cnt", 64'(busy_cnt), 64'd1);
        check("rsv_clr_data", 64'(rdata[0]), 64'h33);
        we_a = 1'b1; waddr_a = 6'd3; wdata_a = 32'h44;
        tick();
        idle();
        #1;
        check("a_no_clear", 64'(rbusy[0]), 64'd1);
        we_b = 1'b1; waddr_b = 6'd3; wdata_b = 32'h55;
        tick();
        idle();
        #1;
        check("b_clear_busy", 64'(rbusy[0]), 64'd0);
        check("b_clear_cnt", 64'(busy_cnt), 64'd0);

        // Three reservations, then flush alongside a new reservation.
        raddr = {6'd4, 6'd2, 6'd1};
        reserve(6'd1);
        reserve(6'd2);
        reserve(6'd4);
        check("three_cnt", 64'(busy_cnt), 64'd3);
        check("three_busy", 64'(rbusy), 64'b111);
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 6'd6;
        #1;
        check("flush_ready", 64'(rsv_ready), 64'd0);
        tick();
        idle();
        #1;
        check("flush_busy", 64'(rbusy), 64'd0);
        check("flush_cnt", 64'(busy_cnt), 64'd0);
        raddr = {6'd0, 6'd0, 6'd6};
        #1;
        check("flush_x6_busy", 64'(rbusy[0]), 64'd0);

        // FP bank f0 is a real register distinct from x0.
        we_a = 1'b1; waddr_a = 6'd32; wdata_a = 32'hA5A5A5A5;
        tick();
        idle();
        raddr = {6'd7, 6'd0, 6'd32};
        #1;
        check("read_f0", 64'(rdata[0]), 64'hA5A5A5A5);
        check("read_x0_fp", 64'(rdata[1]), 64'd0);

        // Reset in mid-operation with three outstanding reservations.
        raddr = {6'd4, 6'd2, 6'd5};
        reserve(6'd1);
        reserve(6'd2);
        reserve(6'd4);
        check("pre_rst_cnt", 64'(busy_cnt), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rbusy", 64'(rbusy), 64'd0);
        check("rst_cnt", 64'(busy_cnt), 64'd0);
        rsv_valid = 1'b1; rsv_addr = 6'd8;
        #1;
        check("rst_ready_comb", 64'(rsv_ready), 64'd1);
        tick();
        check("rst_discard_cnt", 64'(busy_cnt), 64'd0);
        rsv_valid = 1'b0;
        rst_n = 1'b1;
        raddr = {6'd0, 6'd0, 6'd8};
        #1;
        check("post_rst_busy", 64'(rbusy[0]), 64'd0);
        reserve(6'd8);
        check("post_rst_cnt", 64'(busy_cnt), 64'd1);
        check("post_rst_busy8", 64'(rbusy[0]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
